// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the mmio_timer register window: offsets, bit indices, size code.
package mmio_timer_pkg;

    localparam logic [1:0] TMR_CTRL    = 2'd0;
    localparam logic [1:0] TMR_COUNT   = 2'd1;
    localparam logic [1:0] TMR_COMPARE = 2'd2;
    localparam logic [1:0] TMR_STATUS  = 2'd3;

    localparam int unsigned CTRL_EN           = 0;
    localparam int unsigned CTRL_AUTO_RELOAD  = 1;
    localparam int unsigned CTRL_IRQ_EN       = 2;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;

    localparam int unsigned STATUS_MATCH  = 0;
    localparam int unsigned STATUS_OVF    = 1;
    localparam int unsigned STATUS_BUSERR = 2;

    localparam logic [2:0]  SIZE_WORD = 3'd2;

    // Only EN, AUTO_RELOAD, IRQ_EN and PRESCALE are stored; all other CTRL bits read 0.
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

endpackage

// File: rtl/timer_prescaler.sv
// 8-bit prescaler: emits one tick every prescale+1 enabled cycles; holds while disabled.
module timer_prescaler (
    input  logic       CLK,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] cnt;

    assign tick = en && (cnt == prescale);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= tick ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: prescaled up-counter with compare match, overflow and level irq.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        WE,
    input  logic [2:0]  size,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        hit,
    output logic        irq
);

    logic [31:0] ctrlReg;
    logic [31:0] countReg;
    logic [31:0] compareReg;
    logic [2:0]  statusReg;

    logic [1:0]  offset;
    logic        wrAccess;
    logic        wrOk;
    logic        busErr;
    logic        countWr;
    logic        tick;
    logic        tickEff;
    logic        matchEv;
    logic        reloadEv;
    logic        ovfEv;
    logic [2:0]  statusClr;
    logic        unusedAddrBits;

    assign hit            = (A[31:4] == BASE_ADDR[31:4]);
    assign offset         = A[3:2];
    assign unusedAddrBits = ^A[1:0];
    assign wrAccess       = WE && hit;
    assign wrOk           = wrAccess && (size == SIZE_WORD);
    assign busErr         = wrAccess && (size != SIZE_WORD);
    assign countWr        = wrOk && (offset == TMR_COUNT);

    timer_prescaler uPrescaler (
        .CLK      (CLK),
        .reset    (reset),
        .en       (ctrlReg[CTRL_EN]),
        .clr      (countWr),
        .prescale (ctrlReg[CTRL_PRESCALE_LSB +: 8]),
        .tick     (tick)
    );

    // A COUNT write pre-empts the tick entirely, including its match/overflow side effects.
    assign tickEff   = tick && !countWr;
    assign matchEv   = tickEff && (countReg == compareReg);
    assign reloadEv  = matchEv && ctrlReg[CTRL_AUTO_RELOAD];
    assign ovfEv     = tickEff && !reloadEv && (countReg == 32'hFFFF_FFFF);
    assign statusClr = (wrOk && (offset == TMR_STATUS)) ? WD[2:0] : 3'b000;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ctrlReg    <= 32'd0;
            countReg   <= 32'd0;
            compareReg <= 32'hFFFF_FFFF;
            statusReg  <= 3'b000;
        end else begin
            if (wrOk && (offset == TMR_CTRL)) begin
                ctrlReg <= WD & CTRL_MASK;
            end
            if (wrOk && (offset == TMR_COMPARE)) begin
                compareReg <= WD;
            end
            if (countWr) begin
                countReg <= WD;
            end else if (tickEff) begin
                countReg <= reloadEv ? 32'd0 : countReg + 32'd1;
            end
            // Hardware set wins over write-1-to-clear of the same bit.
            statusReg <= (statusReg & ~statusClr) | {busErr, ovfEv, matchEv};
        end
    end

    assign irq = ctrlReg[CTRL_IRQ_EN] && (statusReg[STATUS_MATCH] || statusReg[STATUS_OVF]);

    always_comb begin
        RD = 32'd0;
        if (hit) begin
            unique case (offset)
                TMR_CTRL:    RD = ctrlReg;
                TMR_COUNT:   RD = countReg;
                TMR_COMPARE: RD = compareReg;
                TMR_STATUS:  RD = {29'd0, statusReg};
                default:     RD = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer using immediate assertions.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_CTRL    = BASE + 32'h0;
    localparam logic [31:0] A_COUNT   = BASE + 32'h4;
    localparam logic [31:0] A_COMPARE = BASE + 32'h8;
    localparam logic [31:0] A_STATUS  = BASE + 32'hC;

    logic        CLK;
    logic        reset;
    logic        WE;
    logic [2:0]  size;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        hit;
    logic        irq;

    int errors = 0;
    int checks = 0;

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .CLK   (CLK),
        .reset (reset),
        .WE    (WE),
        .size  (size),
        .A     (A),
        .WD    (WD),
        .RD    (RD),
        .hit   (hit),
        .irq   (irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives a write on the falling edge; it commits on the following rising edge.
    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] sz);
        @(negedge CLK);
        A = addr; WD = data; size = sz; WE = 1'b1;
        @(posedge CLK);
        #1;
        WE = 1'b0; size = 3'd2;
    endtask

    task automatic checkRead(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp);
        A = addr; WE = 1'b0;
        #1;
        check(tag, RD, exp);
    endtask

    initial begin
        reset = 1'b0; WE = 1'b0; size = 3'd2; A = 32'd0; WD = 32'd0;
        #12;
        checkRead("rst_ctrl", A_CTRL, 32'h0);
        checkRead("rst_count", A_COUNT, 32'h0);
        checkRead("rst_compare", A_COMPARE, 32'hFFFF_FFFF);
        checkRead("rst_status", A_STATUS, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge CLK);
        reset = 1'b1;

        // Prescale 3: COUNT increments every 4 cycles.
        busWrite(A_CTRL, 32'h0000_0301, 3'd2);
        repeat (4) @(posedge CLK);
        #1;
        checkRead("presc_cnt1", A_COUNT, 32'd1);
        repeat (16) @(posedge CLK);
        #1;
        checkRead("presc_cnt5", A_COUNT, 32'd5);
        busWrite(A_CTRL, 32'h0000_0300, 3'd2);
        repeat (10) @(posedge CLK);
        #1;
        checkRead("presc_frozen", A_COUNT, 32'd5);

        // Asynchronous reset in the middle of counting.
        busWrite(A_COUNT, 32'h0000_0050, 3'd2);
        busWrite(A_CTRL, 32'h0000_0001, 3'd2);
        busWrite(A_STATUS, 32'h0, 3'd0);
        repeat (2) @(posedge CLK);
        #2;
        reset = 1'b0;
        #1;
        checkRead("arst_count", A_COUNT, 32'h0);
        checkRead("arst_ctrl", A_CTRL, 32'h0);
        checkRead("arst_compare", A_COMPARE, 32'hFFFF_FFFF);
        checkRead("arst_status", A_STATUS, 32'h0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        @(negedge CLK);
        reset = 1'b1;

        // Auto-reload at COMPARE=4 with interrupt enabled, prescale 0.
        busWrite(A_COMPARE, 32'd4, 3'd2);
        busWrite(A_CTRL, 32'h0000_0007, 3'd2);
        checkRead("ar_cnt0", A_COUNT, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge CLK);
            #1;
            checkRead($sformatf("ar_cnt%0d", i), A_COUNT, (i == 5) ? 32'd0 : 32'(i));
            check($sformatf("ar_irq%0d", i), {31'd0, irq}, (i == 5) ? 32'd1 : 32'd0);
        end
        checkRead("ar_status", A_STATUS, 32'h1);
        busWrite(A_STATUS, 32'h1, 3'd2);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        checkRead("w1c_status", A_STATUS, 32'h0);

        // W1C of MATCH on the very edge that sets it again: set wins.
        repeat (3) @(posedge CLK);
        busWrite(A_STATUS, 32'h1, 3'd2);
        checkRead("coll_w1c_status", A_STATUS, 32'h1);
        check("coll_w1c_irq", {31'd0, irq}, 32'd1);
        busWrite(A_STATUS, 32'h1, 3'd2);
        checkRead("coll_w1c_clear", A_STATUS, 32'h0);

        // COUNT write on a tick cycle beats the increment.
        busWrite(A_CTRL, 32'h0000_0001, 3'd2);
        busWrite(A_COUNT, 32'h0000_0010, 3'd2);
        checkRead("coll_cnt_wr", A_COUNT, 32'h10);
        @(posedge CLK);
        #1;
        checkRead("coll_cnt_next", A_COUNT, 32'h11);

        // Overflow without reload.
        busWrite(A_COUNT, 32'hFFFF_FFFE, 3'd2);
        checkRead("ovf_fe", A_COUNT, 32'hFFFF_FFFE);
        @(posedge CLK);
        #1;
        checkRead("ovf_ff", A_COUNT, 32'hFFFF_FFFF);
        @(posedge CLK);
        #1;
        checkRead("ovf_wrap", A_COUNT, 32'h0);
        checkRead("ovf_status", A_STATUS, 32'h2);
        check("ovf_irq_gated", {31'd0, irq}, 32'd0);

        // Non-word write: no commit, BUSERR set; reserved CTRL bits read 0.
        busWrite(A_CTRL, 32'h0, 3'd2);
        busWrite(A_STATUS, 32'h7, 3'd2);
        busWrite(A_CTRL, 32'hFFFF_FFFF, 3'd0);
        checkRead("berr_ctrl", A_CTRL, 32'h0);
        checkRead("berr_status", A_STATUS, 32'h4);
        busWrite(A_CTRL, 32'hFFFF_FF00, 3'd2);
        checkRead("ctrl_mask", A_CTRL, 32'h0000_FF00);
        busWrite(A_CTRL, 32'h0, 3'd2);

        // Decode: window is 16 bytes; A[1:0] ignored.
        busWrite(BASE + 32'h18, 32'h99, 3'd2);
        A = BASE + 32'h10;
        #1;
        check("dec_miss_hit", {31'd0, hit}, 32'd0);
        check("dec_miss_rd", RD, 32'd0);
        checkRead("dec_compare", A_COMPARE, 32'd4);
        check("dec_hit", {31'd0, hit}, 32'd1);
        checkRead("dec_lowbits", BASE + 32'h9, 32'd4);
        checkRead("dec_status", A_STATUS, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
